// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: turns step commands into registered A/B
// waveforms with a programmable number of clock cycles between successive edges.
module quad_encoder_gen #(
  parameter int POS_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [POS_WIDTH-1:0]    cmd_steps,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic                    stop,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    busy,
  output logic                    done,
  output logic [POS_WIDTH-1:0]    position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic [POS_WIDTH-1:0]    steps_q, steps_d;
  logic [POS_WIDTH-1:0]    pos_q, pos_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic                    enc_a_q, enc_a_d;
  logic                    enc_b_q, enc_b_d;
  logic                    done_q, done_d;

  logic [PERIOD_WIDTH-1:0] period_eff;
  logic                    expire;
  logic                    toggle_a;

  assign period_eff = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;
  assign expire     = (timer_q == PERIOD_WIDTH'(1));

  // Gray-code stepping: forward flips A when A==B, reverse flips A when A!=B;
  // in every other case B is the channel that flips.
  assign toggle_a = dir_q ^ (enc_a_q ^ enc_b_q);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    period_d = period_q;
    timer_d  = timer_q;
    enc_a_d  = enc_a_q;
    enc_b_d  = enc_b_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = RUN;
          dir_d    = cmd_dir;
          steps_d  = cmd_steps;
          period_d = period_eff;
          timer_d  = period_eff;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (steps_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (expire) begin
          if (toggle_a) enc_a_d = ~enc_a_q;
          else          enc_b_d = ~enc_b_q;
          pos_d   = dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
          steps_d = steps_q - POS_WIDTH'(1);
          timer_d = period_q;
          if (steps_q == POS_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - PERIOD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      steps_q  <= '0;
      pos_q    <= '0;
      period_q <= '0;
      timer_q  <= '0;
      enc_a_q  <= 1'b0;
      enc_b_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      enc_a_q  <= enc_a_d;
      enc_b_q  <= enc_b_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign cmd_ready = ~busy;
  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign done      = done_q;
  assign position  = pos_q;

endmodule
